// File: rtl/param_array_streamer_if.sv
// Valid/ready beat stream carrying one table entry and its index.
interface param_array_streamer_if #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned IDXW  = 2
);
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [IDXW-1:0]  out_index;
    logic             out_last;

    modport master (
        output out_valid,
        input  out_ready,
        output out_data,
        output out_index,
        output out_last
    );

    modport slave (
        input  out_valid,
        output out_ready,
        input  out_data,
        input  out_index,
        input  out_last
    );
endinterface

// File: rtl/param_array_streamer.sv
// Streams a constant parameter table in index order on start, accumulating
// the sum of every accepted beat.
module param_array_streamer #(
    parameter int unsigned      WIDTH = 32,
    parameter int unsigned      DEPTH = 4,
    parameter logic [WIDTH-1:0] TABLE [0:DEPTH-1] = '{32'd121, 32'd110, 32'd2, 32'd20},
    parameter int unsigned      IDXW  = $clog2(DEPTH)
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    param_array_streamer_if.master     out_if,
    output logic                       busy,
    output logic                       done,
    output logic [WIDTH+IDXW:0]        sum
);
    localparam int unsigned SUMW = WIDTH + IDXW + 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_STREAM,
        S_DONE
    } state_t;

    state_t            state_q, state_d;
    logic              valid_q, valid_d;
    logic              last_q,  last_d;
    logic [IDXW-1:0]   idx_q,   idx_d;
    logic [WIDTH-1:0]  data_q,  data_d;
    logic [SUMW-1:0]   sum_q,   sum_d;
    logic [IDXW-1:0]   idx_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
            idx_q   <= '0;
            data_q  <= '0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            last_q  <= last_d;
            idx_q   <= idx_d;
            data_q  <= data_d;
            sum_q   <= sum_d;
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        last_d  = last_q;
        idx_d   = idx_q;
        data_d  = data_q;
        sum_d   = sum_q;
        idx_nxt = idx_q + 1'b1;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_STREAM;
                    valid_d = 1'b1;
                    idx_d   = '0;
                    data_d  = TABLE[0];
                    last_d  = 1'b0;
                    sum_d   = '0;
                end
            end
            S_STREAM: begin
                if (valid_q && out_if.out_ready) begin
                    sum_d = sum_q + SUMW'(data_q);
                    if (idx_q == LAST_IDX) begin
                        // Outputs fall back to their idle values so data reads zero when invalid.
                        state_d = S_DONE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        idx_d   = '0;
                        data_d  = '0;
                    end else begin
                        idx_d   = idx_nxt;
                        data_d  = TABLE[idx_nxt];
                        last_d  = (idx_nxt == LAST_IDX);
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_if.out_valid = valid_q;
    assign out_if.out_data  = data_q;
    assign out_if.out_index = idx_q;
    assign out_if.out_last  = last_q;
    assign busy             = (state_q == S_STREAM);
    assign done             = (state_q == S_DONE);
    assign sum              = sum_q;
endmodule

// File: tb/tb_param_array_streamer.sv
// Randomised and directed checks of param_array_streamer against a
// position/sum model of the table stream.
module tb_param_array_streamer;
    localparam int DEPTH = 4;
    localparam logic [31:0] TBL       [0:3] = '{32'd121, 32'd110, 32'd2, 32'd20};
    localparam logic [31:0] SMALL_TBL [0:2] = '{32'd5, 32'd7, 32'd9};

    logic        clk = 1'b0;
    logic        rst, start, start2;
    logic        busy, done, busy2, done2;
    logic [34:0] sum, sum2;

    int total = 0;
    int bad   = 0;
    bit chk_en = 1'b0;
    int dut_done_cnt = 0;

    // Model: m_pos = -1 idle, 0..DEPTH-1 beat on the bus, DEPTH the done cycle.
    int     m_pos = -1;
    longint m_sum = 0;

    always #5 clk = ~clk;

    param_array_streamer_if #(.WIDTH(32), .IDXW(2)) bus ();
    param_array_streamer_if #(.WIDTH(32), .IDXW(2)) sbus ();

    param_array_streamer dut (
        .clk    (clk),
        .rst    (rst),
        .start  (start),
        .out_if (bus.master),
        .busy   (busy),
        .done   (done),
        .sum    (sum)
    );

    param_array_streamer #(
        .WIDTH (32),
        .DEPTH (3),
        .TABLE (SMALL_TBL)
    ) u_small (
        .clk    (clk),
        .rst    (rst),
        .start  (start2),
        .out_if (sbus.master),
        .busy   (busy2),
        .done   (done2),
        .sum    (sum2)
    );

    task automatic chk(input string name, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_pos <= -1;
            m_sum <= 0;
        end else if (m_pos == -1) begin
            if (start) begin
                m_pos <= 0;
                m_sum <= 0;
            end
        end else if (m_pos == DEPTH) begin
            m_pos <= -1;
        end else if (bus.out_ready) begin
            m_sum <= m_sum + longint'(TBL[m_pos]);
            m_pos <= m_pos + 1;
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            automatic bit     ev = (m_pos >= 0) && (m_pos < DEPTH);
            automatic longint ed = ev ? longint'(TBL[m_pos]) : 0;
            automatic longint ei = ev ? longint'(m_pos) : 0;
            chk("valid", longint'(bus.out_valid), longint'(ev));
            chk("data",  longint'(bus.out_data), ed);
            chk("index", longint'(bus.out_index), ei);
            chk("last",  longint'(bus.out_last), longint'(m_pos == DEPTH - 1));
            chk("busy",  longint'(busy), longint'(ev));
            chk("done",  longint'(done), longint'(m_pos == DEPTH));
            chk("sum",   longint'(sum), m_sum);
            if (done) dut_done_cnt++;
        end
    end

    task automatic step(input logic s, input logic r);
        start = s;
        bus.out_ready = r;
        @(negedge clk);
    endtask

    initial begin
        int d0;
        logic [6:0] rpat;
        rst = 1'b1;
        start = 1'b0;
        start2 = 1'b0;
        bus.out_ready = 1'b1;
        sbus.out_ready = 1'b1;
        repeat (3) @(negedge clk);

        chk("rst_valid", longint'(bus.out_valid), 0);
        chk("rst_data",  longint'(bus.out_data), 0);
        chk("rst_index", longint'(bus.out_index), 0);
        chk("rst_last",  longint'(bus.out_last), 0);
        chk("rst_busy",  longint'(busy), 0);
        chk("rst_done",  longint'(done), 0);
        chk("rst_sum",   longint'(sum), 0);
        chk_en = 1'b1;
        rst = 1'b0;
        step(0, 1);

        // Single pass, no back-pressure.
        d0 = dut_done_cnt;
        step(1, 1);
        chk("s1_first_data", longint'(bus.out_data), 121);
        chk("s1_first_last", longint'(bus.out_last), 0);
        repeat (3) step(0, 1);
        chk("s1_last_data", longint'(bus.out_data), 20);
        chk("s1_last_idx",  longint'(bus.out_index), 3);
        chk("s1_last_flag", longint'(bus.out_last), 1);
        step(0, 1);
        chk("s1_done_pulse", longint'(done), 1);
        repeat (2) step(0, 1);
        chk("s1_sum", longint'(sum), 253);
        chk("s1_model_sum", m_sum, 253);
        chk("s1_done_cnt", longint'(dut_done_cnt - d0), 1);

        // Back-pressure pattern.
        d0 = dut_done_cnt;
        rpat = 7'b1101001;
        step(1, 1);
        for (int i = 0; i < 7; i++) step(0, rpat[i]);
        repeat (8) step(0, 1);
        chk("s2_sum", longint'(sum), 253);
        chk("s2_done_cnt", longint'(dut_done_cnt - d0), 1);

        // start during STREAM is ignored.
        d0 = dut_done_cnt;
        step(1, 1);
        step(0, 1);
        step(1, 1);
        repeat (6) step(0, 1);
        chk("s3_sum", longint'(sum), 253);
        chk("s3_done_cnt", longint'(dut_done_cnt - d0), 1);

        // Reset mid-pass aborts without done.
        d0 = dut_done_cnt;
        step(1, 1);
        step(0, 1);
        step(0, 1);
        rst = 1'b1;
        step(0, 1);
        rst = 1'b0;
        chk("s4_valid", longint'(bus.out_valid), 0);
        chk("s4_sum", longint'(sum), 0);
        repeat (4) step(0, 1);
        chk("s4_no_done", longint'(dut_done_cnt - d0), 0);
        step(1, 1);
        repeat (6) step(0, 1);
        chk("s4_restart_sum", longint'(sum), 253);

        // start held high: one pass every DEPTH+2 cycles.
        d0 = dut_done_cnt;
        repeat (24) step(1, 1);
        repeat (8) step(0, 1);
        chk("s5_done_cnt", longint'(dut_done_cnt - d0), 4);
        chk("s5_sum", longint'(sum), 253);

        // Randomised traffic with occasional reset.
        for (int i = 0; i < 400; i++) begin
            rst = ($urandom_range(0, 96) == 0);
            step(($urandom_range(0, 4) == 0), ($urandom_range(0, 2) != 0));
        end
        rst = 1'b0;
        repeat (10) step(0, 1);

        // Three-entry override instance.
        start2 = 1'b1;
        @(negedge clk);
        start2 = 1'b0;
        chk("sm_b0_valid", longint'(sbus.out_valid), 1);
        chk("sm_b0_data",  longint'(sbus.out_data), 5);
        chk("sm_b0_last",  longint'(sbus.out_last), 0);
        @(negedge clk);
        chk("sm_b1_data",  longint'(sbus.out_data), 7);
        chk("sm_b1_idx",   longint'(sbus.out_index), 1);
        @(negedge clk);
        chk("sm_b2_data",  longint'(sbus.out_data), 9);
        chk("sm_b2_idx",   longint'(sbus.out_index), 2);
        chk("sm_b2_last",  longint'(sbus.out_last), 1);
        @(negedge clk);
        chk("sm_done",     longint'(done2), 1);
        chk("sm_valid",    longint'(sbus.out_valid), 0);
        chk("sm_sum",      longint'(sum2), 21);
        @(negedge clk);
        chk("sm_done_drop", longint'(done2), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
